// File: rtl/paddle_ctrl.sv
// Paddle position controller: accelerating button-driven movement along one axis with edge clamping and recentring.
// Latency: state updates one clock after a qualified strobe; edge outputs are combinational from registers. No backpressure.
module paddle_ctrl #(
    parameter int HW           = 40,
    parameter int HT           = 8,
    parameter int IX           = 320,
    parameter int IY           = 440,
    parameter int D_WIDTH      = 640,
    parameter int D_HEIGHT     = 480,
    parameter int AXIS         = 0,
    parameter int MAX_SPEED    = 4,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_neg_btn,
    input  logic        i_pos_btn,
    input  logic        i_center,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [3:0]  o_speed,
    output logic [1:0]  o_state,
    output logic        o_at_min,
    output logic        o_at_max
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCEL    = 2'd1,
        CRUISE   = 2'd2,
        RECENTER = 2'd3
    } state_t;

    localparam int CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [11:0]        HW12     = 12'(HW);
    localparam logic [11:0]        HT12     = 12'(HT);
    localparam logic [11:0]        IX12     = 12'(IX);
    localparam logic [11:0]        IY12     = 12'(IY);
    localparam logic [11:0]        MINP     = 12'(HW);
    localparam logic [11:0]        MAXP     = 12'((AXIS == 0) ? (D_WIDTH - HW) : (D_HEIGHT - HW));
    localparam logic [11:0]        P0       = 12'((AXIS == 0) ? IX : IY);
    localparam logic [3:0]         MAXS     = 4'(MAX_SPEED);
    localparam logic [CW-1:0]      CNT_LAST = CW'(ACCEL_FRAMES - 1);
    localparam logic signed [12:0] MINP_S   = signed'({1'b0, MINP});
    localparam logic signed [12:0] MAXP_S   = signed'({1'b0, MAXP});
    localparam logic signed [12:0] P0_S     = signed'({1'b0, P0});

    state_t        state;
    logic [11:0]   p;
    logic [3:0]    speed;
    logic [CW-1:0] cnt;
    logic          dir;        // 1 = toward increasing coordinate

    logic              stb;
    logic              req_vld;
    logic              req_same;
    logic signed [12:0] p_s;
    logic signed [12:0] sp_s;
    logic signed [12:0] p_inc;
    logic signed [12:0] p_dec;
    logic              hit_max;
    logic              hit_min;
    logic              clamp;
    logic [11:0]       p_moved;
    logic signed [12:0] diff;
    logic [12:0]       adiff;
    logic              near;
    logic [11:0]       p_step;

    assign stb      = i_animate & i_ani_stb;
    assign req_vld  = i_neg_btn ^ i_pos_btn;
    assign req_same = req_vld && (i_pos_btn == dir);

    // Signed 13-bit math so a decrement below zero still compares correctly against MINP.
    assign p_s     = signed'({1'b0, p});
    assign sp_s    = signed'({9'd0, speed});
    assign p_inc   = p_s + sp_s;
    assign p_dec   = p_s - sp_s;
    assign hit_max = p_inc > MAXP_S;
    assign hit_min = p_dec < MINP_S;
    assign clamp   = dir ? hit_max : hit_min;
    assign p_moved = dir ? (hit_max ? MAXP : p_inc[11:0])
                         : (hit_min ? MINP : p_dec[11:0]);

    assign diff   = p_s - P0_S;
    assign adiff  = diff[12] ? unsigned'(-diff) : unsigned'(diff);
    assign near   = adiff <= 13'(MAX_SPEED);
    assign p_step = (p > P0) ? (p - 12'(MAX_SPEED)) : (p + 12'(MAX_SPEED));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            p     <= P0;
            speed <= 4'd0;
            cnt   <= '0;
            dir   <= 1'b1;
            state <= IDLE;
        end else if (stb) begin
            if (i_center && state != RECENTER) begin
                state <= RECENTER;
                speed <= MAXS;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_vld) begin
                            dir   <= i_pos_btn;
                            speed <= 4'd1;
                            cnt   <= '0;
                            state <= ACCEL;
                        end else begin
                            speed <= 4'd0;
                        end
                    end
                    ACCEL, CRUISE: begin
                        if (!req_same) begin
                            speed <= 4'd0;
                            state <= IDLE;
                        end else begin
                            p <= p_moved;
                            if (clamp) begin
                                speed <= 4'd0;
                                state <= IDLE;
                            end else if (state == ACCEL) begin
                                if (cnt == CNT_LAST) begin
                                    cnt <= '0;
                                    if (speed < MAXS) speed <= speed + 4'd1;
                                    if (speed >= MAXS - 4'd1) state <= CRUISE;
                                end else begin
                                    cnt <= cnt + CW'(1);
                                end
                            end
                        end
                    end
                    RECENTER: begin
                        if (near) begin
                            p     <= P0;
                            speed <= 4'd0;
                            state <= IDLE;
                        end else begin
                            p <= p_step;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_x1     = (AXIS == 0) ? (p - HW12) : (IX12 - HT12);
    assign o_x2     = (AXIS == 0) ? (p + HW12) : (IX12 + HT12);
    assign o_y1     = (AXIS == 0) ? (IY12 - HT12) : (p - HW12);
    assign o_y2     = (AXIS == 0) ? (IY12 + HT12) : (p + HW12);
    assign o_speed  = speed;
    assign o_state  = state;
    assign o_at_min = (p == MINP);
    assign o_at_max = (p == MAXP);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: horizontal instance for motion/recentre/reset, vertical instance for the min clamp.
module tb_paddle_ctrl;

    logic i_clk = 1'b0;
    logic i_rst_n, i_ani_stb, i_animate;
    logic neg_btn, pos_btn, center;
    logic neg_b, pos_b, center_b;

    logic [11:0] x1, x2, y1, y2;
    logic [3:0]  speed;
    logic [1:0]  state;
    logic        at_min, at_max;

    logic [11:0] b_x1, b_x2, b_y1, b_y2;
    logic [3:0]  b_speed;
    logic [1:0]  b_state;
    logic        b_at_min, b_at_max;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    paddle_ctrl dut_h (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
        .i_neg_btn(neg_btn), .i_pos_btn(pos_btn), .i_center(center),
        .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
        .o_speed(speed), .o_state(state), .o_at_min(at_min), .o_at_max(at_max)
    );

    paddle_ctrl #(.AXIS(1)) dut_v (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
        .i_neg_btn(neg_b), .i_pos_btn(pos_b), .i_center(center_b),
        .o_x1(b_x1), .o_x2(b_x2), .o_y1(b_y1), .o_y2(b_y2),
        .o_speed(b_speed), .o_state(b_state), .o_at_min(b_at_min), .o_at_max(b_at_max)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // n back-to-back strobe cycles; returns at a falling edge so outputs are settled
    task automatic strobe(input int n);
        @(negedge i_clk);
        i_ani_stb = 1'b1;
        repeat (n) @(negedge i_clk);
        i_ani_stb = 1'b0;
    endtask

    task automatic do_reset(input logic with_stb);
        @(negedge i_clk);
        i_rst_n   = 1'b0;
        i_ani_stb = with_stb;
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        i_ani_stb = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x1"}, x1, 280);
        chk({tag, "_speed"}, speed, 0);
        chk({tag, "_state"}, state, 0);
    endtask

    initial begin
        i_rst_n = 1'b0; i_ani_stb = 1'b0; i_animate = 1'b1;
        neg_btn = 0; pos_btn = 0; center = 0;
        neg_b = 0; pos_b = 0; center_b = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // reset values, both axes
        chk("rst_x1", x1, 280);  chk("rst_x2", x2, 360);
        chk("rst_y1", y1, 432);  chk("rst_y2", y2, 448);
        chk("rst_speed", speed, 0); chk("rst_state", state, 0);
        chk("rst_at_min", at_min, 0); chk("rst_at_max", at_max, 0);
        chk("v_rst_x1", b_x1, 312); chk("v_rst_x2", b_x2, 328);
        chk("v_rst_y1", b_y1, 400); chk("v_rst_y2", b_y2, 480);
        chk("v_rst_at_max", b_at_max, 1);

        // acceleration profile
        pos_btn = 1;
        strobe(9);
        chk("acc9_x1", x1, 288); chk("acc9_speed", speed, 2); chk("acc9_state", state, 1);
        strobe(8);
        chk("acc17_x1", x1, 304); chk("acc17_speed", speed, 3);

        // animate low freezes everything even with strobes and a button
        i_animate = 0;
        strobe(5);
        chk("frz_x1", x1, 304); chk("frz_speed", speed, 3); chk("frz_state", state, 1);
        i_animate = 1;

        // reach cruise then clamp at the right edge
        strobe(8);
        chk("cru_x1", x1, 328); chk("cru_speed", speed, 4); chk("cru_state", state, 2);
        strobe(58);
        chk("edge_x2", x2, 640); chk("edge_at_max", at_max, 1); chk("edge_speed", speed, 4);
        strobe(1);
        chk("clamp_x2", x2, 640); chk("clamp_speed", speed, 0);
        chk("clamp_state", state, 0); chk("clamp_at_max", at_max, 1);

        // direction reversal from cruise
        do_reset(1'b0);
        strobe(25);
        chk("rev_pre_state", state, 2);
        pos_btn = 0; neg_btn = 1;
        strobe(1);
        chk("rev_stop_x1", x1, 328); chk("rev_stop_speed", speed, 0); chk("rev_stop_state", state, 0);
        strobe(1);
        chk("rev_go_speed", speed, 1); chk("rev_go_state", state, 1); chk("rev_go_x1", x1, 328);
        strobe(1);
        chk("rev_neg_x1", x1, 327);

        // reset overrides a strobe mid-ACCEL
        do_reset(1'b1);
        chk_reset("rst_acc");

        // build p=343, then recentre
        neg_btn = 0; pos_btn = 1;
        strobe(17);
        pos_btn = 0;
        strobe(1);
        neg_btn = 1;
        strobe(2);
        chk("pre_c_x1", x1, 303);
        neg_btn = 0; center = 1;
        strobe(1);
        chk("c_state", state, 3); chk("c_speed", speed, 4); chk("c_x1", x1, 303);
        center = 0;
        strobe(1);
        chk("c1_x1", x1, 299); chk("c1_state", state, 3);
        strobe(4);
        chk("c5_x1", x1, 283);
        strobe(1);
        chk("c_done_x1", x1, 280); chk("c_done_state", state, 0); chk("c_done_speed", speed, 0);

        // center ignored in RECENTER, buttons ignored, then reset mid-RECENTER
        pos_btn = 1;
        strobe(17);
        center = 1;
        strobe(1);
        strobe(1);
        chk("rc_hold_x1", x1, 300); chk("rc_hold_speed", speed, 4); chk("rc_hold_state", state, 3);
        center = 0;
        do_reset(1'b1);
        chk_reset("rst_rc");

        // both buttons = no request
        pos_btn = 1; neg_btn = 1;
        strobe(5);
        chk("both_x1", x1, 280); chk("both_speed", speed, 0); chk("both_state", state, 0);
        pos_btn = 0; neg_btn = 0;

        // vertical instance: run down to the top clamp
        neg_b = 1;
        begin
            int k = 0;
            while (!b_at_min && k < 300) begin
                strobe(1);
                k++;
                chk("v_x1_const", b_x1, 312);
            end
            chk("v_min_reached", int'(b_at_min), 1);
        end
        chk("v_min_y1", b_y1, 0); chk("v_min_y2", b_y2, 80); chk("v_x2", b_x2, 328);
        strobe(1);
        chk("v_clamp_y1", b_y1, 0); chk("v_clamp_speed", b_speed, 0);
        chk("v_clamp_state", b_state, 0); chk("v_clamp_at_min", b_at_min, 1);
        neg_b = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
